sram_axil_arbiter: RTL and testbench

//  Shares the single AXI-Lite SRAM slave between two masters (m0 = instruction fetch, m1 = data/load-store).
//  The read path and the write path are arbitrated independently, each with its own FSM.

---
 rtl/sram_axil_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_sram_axil_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axil_arbiter.sv
// Two-master AXI-Lite arbiter in front of one SRAM slave.
// Read and write paths each run their own FSM and hold one locked transaction at a time.
module sram_axil_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  m0_readAddr_addr,
    input  logic         m0_readAddr_valid,
    output logic         m0_readAddr_ready,
    output logic [127:0] m0_readData_data,
    output logic         m0_readData_valid,
    input  logic         m0_readData_ready,
    input  logic [31:0]  m0_writeAddr_addr,
    input  logic         m0_writeAddr_valid,
    output logic         m0_writeAddr_ready,
    input  logic [127:0] m0_writeData_data,
    input  logic [15:0]  m0_writeData_strb,
    input  logic         m0_writeData_valid,
    output logic         m0_writeData_ready,
    output logic [31:0]  m0_writeResp_msg,
    output logic         m0_writeResp_valid,
    input  logic         m0_writeResp_ready,

    input  logic [31:0]  m1_readAddr_addr,
    input  logic         m1_readAddr_valid,
    output logic         m1_readAddr_ready,
    output logic [127:0] m1_readData_data,
    output logic         m1_readData_valid,
    input  logic         m1_readData_ready,
    input  logic [31:0]  m1_writeAddr_addr,
    input  logic         m1_writeAddr_valid,
    output logic         m1_writeAddr_ready,
    input  logic [127:0] m1_writeData_data,
    input  logic [15:0]  m1_writeData_strb,
    input  logic         m1_writeData_valid,
    output logic         m1_writeData_ready,
    output logic [31:0]  m1_writeResp_msg,
    output logic         m1_writeResp_valid,
    input  logic         m1_writeResp_ready,

    output logic [31:0]  s_readAddr_addr,
    output logic         s_readAddr_valid,
    input  logic         s_readAddr_ready,
    input  logic [127:0] s_readData_data,
    input  logic         s_readData_valid,
    output logic         s_readData_ready,
    output logic [31:0]  s_writeAddr_addr,
    output logic         s_writeAddr_valid,
    input  logic         s_writeAddr_ready,
    output logic [127:0] s_writeData_data,
    output logic [15:0]  s_writeData_strb,
    output logic         s_writeData_valid,
    input  logic         s_writeData_ready,
    input  logic [31:0]  s_writeResp_msg,
    input  logic         s_writeResp_valid,
    output logic         s_writeResp_ready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;

    rstate_e rstate_q, rstate_d;
    logic    rgnt_q, rgnt_d;
    logic    last_r_q, last_r_d;

    wstate_e wstate_q, wstate_d;
    logic    wgnt_q, wgnt_d;
    logic    last_w_q, last_w_d;
    logic    aw_done_q, aw_done_d;
    logic    w_done_q, w_done_d;

    logic    gArValid, gRReady;
    logic    gAwValid, gWValid, gBReady;
    logic    awFire, wFire;

    // Grant 0 selects m0, 1 selects m1; a tie goes to the master not served last unless m0 has fixed priority.
    function automatic logic pickGrant(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return (PRIO_MODE == 1) ? 1'b0 : ~last;
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

    assign gArValid = rgnt_q ? m1_readAddr_valid  : m0_readAddr_valid;
    assign gRReady  = rgnt_q ? m1_readData_ready  : m0_readData_ready;
    assign gAwValid = wgnt_q ? m1_writeAddr_valid : m0_writeAddr_valid;
    assign gWValid  = wgnt_q ? m1_writeData_valid : m0_writeData_valid;
    assign gBReady  = wgnt_q ? m1_writeResp_ready : m0_writeResp_ready;

    assign s_readAddr_addr  = rgnt_q ? m1_readAddr_addr  : m0_readAddr_addr;
    assign s_writeAddr_addr = wgnt_q ? m1_writeAddr_addr : m0_writeAddr_addr;
    assign s_writeData_data = wgnt_q ? m1_writeData_data : m0_writeData_data;
    assign s_writeData_strb = wgnt_q ? m1_writeData_strb : m0_writeData_strb;

    assign m0_readData_data = s_readData_data;
    assign m1_readData_data = s_readData_data;
    assign m0_writeResp_msg = s_writeResp_msg;
    assign m1_writeResp_msg = s_writeResp_msg;

    // Done flags keep an already-accepted write channel from being re-offered while the other one waits.
    assign awFire = (wstate_q == W_REQ) && gAwValid && !aw_done_q && s_writeAddr_ready;
    assign wFire  = (wstate_q == W_REQ) && gWValid  && !w_done_q  && s_writeData_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rgnt_q   <= 1'b0;
            last_r_q <= 1'b1;
        end else begin
            rstate_q <= rstate_d;
            rgnt_q   <= rgnt_d;
            last_r_q <= last_r_d;
        end
    end

    always_comb begin
        rstate_d          = rstate_q;
        rgnt_d            = rgnt_q;
        last_r_d          = last_r_q;
        s_readAddr_valid  = 1'b0;
        s_readData_ready  = 1'b0;
        m0_readAddr_ready = 1'b0;
        m1_readAddr_ready = 1'b0;
        m0_readData_valid = 1'b0;
        m1_readData_valid = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (m0_readAddr_valid || m1_readAddr_valid) begin
                    rgnt_d   = pickGrant(m0_readAddr_valid, m1_readAddr_valid, last_r_q);
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                s_readAddr_valid  = gArValid;
                m0_readAddr_ready = !rgnt_q && s_readAddr_ready;
                m1_readAddr_ready = rgnt_q && s_readAddr_ready;
                if (gArValid && s_readAddr_ready) begin
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                m0_readData_valid = !rgnt_q && s_readData_valid;
                m1_readData_valid = rgnt_q && s_readData_valid;
                s_readData_ready  = gRReady;
                if (s_readData_valid && gRReady) begin
                    rstate_d = R_IDLE;
                    last_r_d = rgnt_q;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            wgnt_q    <= 1'b0;
            last_w_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            wgnt_q    <= wgnt_d;
            last_w_q  <= last_w_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        wstate_d           = wstate_q;
        wgnt_d             = wgnt_q;
        last_w_d           = last_w_q;
        aw_done_d          = aw_done_q;
        w_done_d           = w_done_q;
        s_writeAddr_valid  = 1'b0;
        s_writeData_valid  = 1'b0;
        s_writeResp_ready  = 1'b0;
        m0_writeAddr_ready = 1'b0;
        m1_writeAddr_ready = 1'b0;
        m0_writeData_ready = 1'b0;
        m1_writeData_ready = 1'b0;
        m0_writeResp_valid = 1'b0;
        m1_writeResp_valid = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (m0_writeAddr_valid || m0_writeData_valid ||
                    m1_writeAddr_valid || m1_writeData_valid) begin
                    wgnt_d    = pickGrant(m0_writeAddr_valid || m0_writeData_valid,
                                          m1_writeAddr_valid || m1_writeData_valid, last_w_q);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_REQ;
                end
            end
            W_REQ: begin
                s_writeAddr_valid  = gAwValid && !aw_done_q;
                s_writeData_valid  = gWValid && !w_done_q;
                m0_writeAddr_ready = !wgnt_q && !aw_done_q && s_writeAddr_ready;
                m1_writeAddr_ready = wgnt_q && !aw_done_q && s_writeAddr_ready;
                m0_writeData_ready = !wgnt_q && !w_done_q && s_writeData_ready;
                m1_writeData_ready = wgnt_q && !w_done_q && s_writeData_ready;
                aw_done_d          = aw_done_q || awFire;
                w_done_d           = w_done_q || wFire;
                if (aw_done_d && w_done_d) begin
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                m0_writeResp_valid = !wgnt_q && s_writeResp_valid;
                m1_writeResp_valid = wgnt_q && s_writeResp_valid;
                s_writeResp_ready  = gBReady;
                if (s_writeResp_valid && gBReady) begin
                    wstate_d = W_IDLE;
                    last_w_d = wgnt_q;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_axil_arbiter.sv
// Bench for sram_axil_arbiter: one instance per PRIO_MODE sharing all inputs, checked every cycle
// against a transaction-level model, plus directed literal expectations per scenario.
module tb_sram_axil_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]  mArAddr [2];
    logic         mArValid [2];
    logic         mRReady [2];
    logic [31:0]  mAwAddr [2];
    logic         mAwValid [2];
    logic [127:0] mWData [2];
    logic [15:0]  mWStrb [2];
    logic         mWValid [2];
    logic         mBReady [2];

    logic         sArReady, sRValid, sAwReady, sWReady, sBValid;
    logic [127:0] sRData;
    logic [31:0]  sBMsg;

    logic         oArReady [2][2];
    logic [127:0] oRData [2][2];
    logic         oRValid [2][2];
    logic         oAwReady [2][2];
    logic         oWReady [2][2];
    logic [31:0]  oBMsg [2][2];
    logic         oBValid [2][2];
    logic [31:0]  oSArAddr [2];
    logic         oSArValid [2];
    logic         oSRReady [2];
    logic [31:0]  oSAwAddr [2];
    logic         oSAwValid [2];
    logic [127:0] oSWData [2];
    logic [15:0]  oSWStrb [2];
    logic         oSWValid [2];
    logic         oSBReady [2];

    generate
        for (genvar g = 0; g < 2; g++) begin : gDut
            sram_axil_arbiter #(.PRIO_MODE(g)) dut (
                .clk(clk), .rst(rst),
                .m0_readAddr_addr(mArAddr[0]), .m0_readAddr_valid(mArValid[0]), .m0_readAddr_ready(oArReady[g][0]),
                .m0_readData_data(oRData[g][0]), .m0_readData_valid(oRValid[g][0]), .m0_readData_ready(mRReady[0]),
                .m0_writeAddr_addr(mAwAddr[0]), .m0_writeAddr_valid(mAwValid[0]), .m0_writeAddr_ready(oAwReady[g][0]),
                .m0_writeData_data(mWData[0]), .m0_writeData_strb(mWStrb[0]), .m0_writeData_valid(mWValid[0]),
                .m0_writeData_ready(oWReady[g][0]),
                .m0_writeResp_msg(oBMsg[g][0]), .m0_writeResp_valid(oBValid[g][0]), .m0_writeResp_ready(mBReady[0]),
                .m1_readAddr_addr(mArAddr[1]), .m1_readAddr_valid(mArValid[1]), .m1_readAddr_ready(oArReady[g][1]),
                .m1_readData_data(oRData[g][1]), .m1_readData_valid(oRValid[g][1]), .m1_readData_ready(mRReady[1]),
                .m1_writeAddr_addr(mAwAddr[1]), .m1_writeAddr_valid(mAwValid[1]), .m1_writeAddr_ready(oAwReady[g][1]),
                .m1_writeData_data(mWData[1]), .m1_writeData_strb(mWStrb[1]), .m1_writeData_valid(mWValid[1]),
                .m1_writeData_ready(oWReady[g][1]),
                .m1_writeResp_msg(oBMsg[g][1]), .m1_writeResp_valid(oBValid[g][1]), .m1_writeResp_ready(mBReady[1]),
                .s_readAddr_addr(oSArAddr[g]), .s_readAddr_valid(oSArValid[g]), .s_readAddr_ready(sArReady),
                .s_readData_data(sRData), .s_readData_valid(sRValid), .s_readData_ready(oSRReady[g]),
                .s_writeAddr_addr(oSAwAddr[g]), .s_writeAddr_valid(oSAwValid[g]), .s_writeAddr_ready(sAwReady),
                .s_writeData_data(oSWData[g]), .s_writeData_strb(oSWStrb[g]), .s_writeData_valid(oSWValid[g]),
                .s_writeData_ready(sWReady),
                .s_writeResp_msg(sBMsg), .s_writeResp_valid(sBValid), .s_writeResp_ready(oSBReady[g])
            );
        end
    endgenerate

    int testCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: each path is either free or owned by one master; the write
    // response phase is simply "both channels accepted".
    bit modelOn = 1'b0;
    bit rBusy [2], rAddrDone [2], wBusy [2], awDone [2], wDone [2];
    int rOwner [2], rLast [2], wOwner [2], wLast [2];
    int roT, woT;

    function automatic int pickOwner(input int mode, input logic req0, input logic req1, input int last);
        if (req0 && req1) return (mode == 1) ? 0 : 1 - last;
        return req0 ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            modelOn <= 1'b1;
            for (int g = 0; g < 2; g++) begin
                rBusy[g] <= 1'b0; rAddrDone[g] <= 1'b0; rLast[g] <= 1; rOwner[g] <= 0;
                wBusy[g] <= 1'b0; awDone[g] <= 1'b0; wDone[g] <= 1'b0; wLast[g] <= 1; wOwner[g] <= 0;
            end
        end else if (modelOn) begin
            for (int g = 0; g < 2; g++) begin
                roT = rOwner[g];
                if (!rBusy[g]) begin
                    if (mArValid[0] || mArValid[1]) begin
                        rBusy[g] <= 1'b1;
                        rAddrDone[g] <= 1'b0;
                        rOwner[g] <= pickOwner(g, mArValid[0], mArValid[1], rLast[g]);
                    end
                end else if (!rAddrDone[g]) begin
                    if (mArValid[roT] && sArReady) rAddrDone[g] <= 1'b1;
                end else if (sRValid && mRReady[roT]) begin
                    rBusy[g] <= 1'b0;
                    rLast[g] <= roT;
                end

                woT = wOwner[g];
                if (!wBusy[g]) begin
                    if (mAwValid[0] || mWValid[0] || mAwValid[1] || mWValid[1]) begin
                        wBusy[g] <= 1'b1;
                        awDone[g] <= 1'b0;
                        wDone[g] <= 1'b0;
                        wOwner[g] <= pickOwner(g, mAwValid[0] || mWValid[0], mAwValid[1] || mWValid[1], wLast[g]);
                    end
                end else if (!(awDone[g] && wDone[g])) begin
                    if (mAwValid[woT] && sAwReady) awDone[g] <= 1'b1;
                    if (mWValid[woT] && sWReady) wDone[g] <= 1'b1;
                end else if (sBValid && mBReady[woT]) begin
                    wBusy[g] <= 1'b0;
                    wLast[g] <= woT;
                end
            end
        end
    end

    // Observation counters used by the directed literal expectations
    int grantLogA [$];
    int grantLogB [$];
    int sWHs [2], sAwHs [2], m0BValidCyc [2], m1BHs [2], bothActive [2];
    logic [15:0] lastStrb [2];
    logic [31:0] lastAwAddr [2];

    logic expArRdy [2], expRVal [2], expAwRdy [2], expWRdy [2], expBVal [2];
    logic expSArVal, expSRRdy, expSAwVal, expSWVal, expSBRdy;
    int   co, cw;

    always @(negedge clk) begin
        if (modelOn) begin
            for (int g = 0; g < 2; g++) begin
                for (int m = 0; m < 2; m++) begin
                    expArRdy[m] = 1'b0; expRVal[m] = 1'b0; expAwRdy[m] = 1'b0;
                    expWRdy[m] = 1'b0; expBVal[m] = 1'b0;
                end
                expSArVal = 1'b0; expSRRdy = 1'b0; expSAwVal = 1'b0; expSWVal = 1'b0; expSBRdy = 1'b0;
                co = rOwner[g];
                cw = wOwner[g];
                if (rBusy[g] && !rAddrDone[g]) begin
                    expSArVal = mArValid[co];
                    expArRdy[co] = sArReady;
                end else if (rBusy[g]) begin
                    expRVal[co] = sRValid;
                    expSRRdy = mRReady[co];
                end
                if (wBusy[g] && !(awDone[g] && wDone[g])) begin
                    expSAwVal = mAwValid[cw] && !awDone[g];
                    expSWVal = mWValid[cw] && !wDone[g];
                    expAwRdy[cw] = sAwReady && !awDone[g];
                    expWRdy[cw] = sWReady && !wDone[g];
                end else if (wBusy[g]) begin
                    expBVal[cw] = sBValid;
                    expSBRdy = mBReady[cw];
                end

                for (int m = 0; m < 2; m++) begin
                    checkOutput($sformatf("g%0d.m%0d.readAddr_ready", g, m), oArReady[g][m], expArRdy[m]);
                    checkOutput($sformatf("g%0d.m%0d.readData_valid", g, m), oRValid[g][m], expRVal[m]);
                    checkOutput($sformatf("g%0d.m%0d.readData_data", g, m), oRData[g][m], sRData);
                    checkOutput($sformatf("g%0d.m%0d.writeAddr_ready", g, m), oAwReady[g][m], expAwRdy[m]);
                    checkOutput($sformatf("g%0d.m%0d.writeData_ready", g, m), oWReady[g][m], expWRdy[m]);
                    checkOutput($sformatf("g%0d.m%0d.writeResp_valid", g, m), oBValid[g][m], expBVal[m]);
                    checkOutput($sformatf("g%0d.m%0d.writeResp_msg", g, m), oBMsg[g][m], sBMsg);
                end
                checkOutput($sformatf("g%0d.s.readAddr_valid", g), oSArValid[g], expSArVal);
                checkOutput($sformatf("g%0d.s.readData_ready", g), oSRReady[g], expSRRdy);
                checkOutput($sformatf("g%0d.s.writeAddr_valid", g), oSAwValid[g], expSAwVal);
                checkOutput($sformatf("g%0d.s.writeData_valid", g), oSWValid[g], expSWVal);
                checkOutput($sformatf("g%0d.s.writeResp_ready", g), oSBReady[g], expSBRdy);
                if (expSArVal) checkOutput($sformatf("g%0d.s.readAddr_addr", g), oSArAddr[g], mArAddr[co]);
                if (expSAwVal) checkOutput($sformatf("g%0d.s.writeAddr_addr", g), oSAwAddr[g], mAwAddr[cw]);
                if (expSWVal) begin
                    checkOutput($sformatf("g%0d.s.writeData_data", g), oSWData[g], mWData[cw]);
                    checkOutput($sformatf("g%0d.s.writeData_strb", g), oSWStrb[g], mWStrb[cw]);
                end

                for (int m = 0; m < 2; m++) begin
                    if (oArReady[g][m] && mArValid[m]) begin
                        if (g == 0) grantLogA.push_back(m);
                        else grantLogB.push_back(m);
                    end
                end
                if (oSWValid[g] && sWReady) begin
                    sWHs[g]++;
                    lastStrb[g] = oSWStrb[g];
                end
                if (oSAwValid[g] && sAwReady) begin
                    sAwHs[g]++;
                    lastAwAddr[g] = oSAwAddr[g];
                end
                if (oBValid[g][0]) m0BValidCyc[g]++;
                if (oBValid[g][1] && mBReady[1]) m1BHs[g]++;
                if (oSArValid[g] && oSAwValid[g]) bothActive[g]++;
            end
        end
    end

    task automatic idleInputs();
        for (int m = 0; m < 2; m++) begin
            mArAddr[m] = 32'h0; mArValid[m] = 1'b0; mRReady[m] = 1'b0;
            mAwAddr[m] = 32'h0; mAwValid[m] = 1'b0; mWData[m] = '0; mWStrb[m] = 16'h0;
            mWValid[m] = 1'b0; mBReady[m] = 1'b0;
        end
        sArReady = 1'b0; sRValid = 1'b0; sRData = '0;
        sAwReady = 1'b0; sWReady = 1'b0; sBValid = 1'b0; sBMsg = 32'h0;
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        applyStimulus(2);
        rst = 1'b0;
        grantLogA.delete();
        grantLogB.delete();
        for (int g = 0; g < 2; g++) begin
            sWHs[g] = 0; sAwHs[g] = 0; m0BValidCyc[g] = 0; m1BHs[g] = 0; bothActive[g] = 0;
            lastStrb[g] = 16'h0; lastAwAddr[g] = 32'h0;
        end
    endtask

    int expA [4] = '{0, 1, 0, 1};
    int expB [4] = '{0, 0, 0, 0};

    initial begin
        idleInputs();
        doReset();
        #1;
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("reset.g%0d.sArValid", g), oSArValid[g], 1'b0);
            checkOutput($sformatf("reset.g%0d.sAwValid", g), oSAwValid[g], 1'b0);
            checkOutput($sformatf("reset.g%0d.sWValid", g), oSWValid[g], 1'b0);
            checkOutput($sformatf("reset.g%0d.sRReady", g), oSRReady[g], 1'b0);
            checkOutput($sformatf("reset.g%0d.sBReady", g), oSBReady[g], 1'b0);
        end

        // A: lone m0 read; slave valid appears one cycle after the request is seen
        doReset();
        sArReady = 1'b1; mRReady[0] = 1'b1; mRReady[1] = 1'b1;
        mArAddr[0] = 32'h0000_0010; mArValid[0] = 1'b1;
        #1;
        checkOutput("A.sArValid.cycle1", oSArValid[0], 1'b0);
        applyStimulus(1);
        #1;
        checkOutput("A.sArValid.cycle2", oSArValid[0], 1'b1);
        checkOutput("A.sArAddr", oSArAddr[0], 32'h0000_0010);
        checkOutput("A.m0.arReady", oArReady[0][0], 1'b1);
        checkOutput("A.m1.arReady", oArReady[0][1], 1'b0);
        applyStimulus(1);
        mArValid[0] = 1'b0; sRValid = 1'b1; sRData = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_1234;
        #1;
        checkOutput("A.m0.rValid", oRValid[0][0], 1'b1);
        checkOutput("A.m1.rValid", oRValid[0][1], 1'b0);
        checkOutput("A.m1.rData", oRData[0][1], 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_1234);
        applyStimulus(1);
        sRValid = 1'b0;
        applyStimulus(2);

        // B: both masters keep requesting reads for four back-to-back transactions
        doReset();
        sArReady = 1'b1; sRValid = 1'b1; mRReady[0] = 1'b1; mRReady[1] = 1'b1;
        mArAddr[0] = 32'h100; mArAddr[1] = 32'h200;
        mArValid[0] = 1'b1; mArValid[1] = 1'b1;
        applyStimulus(12);
        mArValid[0] = 1'b0; mArValid[1] = 1'b0;
        applyStimulus(2);
        sRValid = 1'b0;
        checkOutput("B.rr.count", grantLogA.size(), 4);
        checkOutput("B.prio.count", grantLogB.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grantLogA.size()) checkOutput($sformatf("B.rr.grant%0d", i), grantLogA[i], expA[i]);
            if (i < grantLogB.size()) checkOutput($sformatf("B.prio.grant%0d", i), grantLogB[i], expB[i]);
        end

        // C: m1 write data arrives two cycles ahead of its address
        doReset();
        sAwReady = 1'b1; sWReady = 1'b1; mBReady[0] = 1'b1; mBReady[1] = 1'b1;
        mWData[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888; mWStrb[1] = 16'h000F;
        mWValid[1] = 1'b1;
        applyStimulus(2);
        mAwAddr[1] = 32'h0000_0020; mAwValid[1] = 1'b1;
        #1;
        checkOutput("C.sWValid.doneGated", oSWValid[0], 1'b0);
        checkOutput("C.sAwValid.waiting", oSAwValid[0], 1'b1);
        applyStimulus(1);
        mAwValid[1] = 1'b0; mWValid[1] = 1'b0; sBValid = 1'b1; sBMsg = 32'hB0B0_0001;
        #1;
        checkOutput("C.m1.bValid", oBValid[0][1], 1'b1);
        checkOutput("C.m0.bValid", oBValid[0][0], 1'b0);
        applyStimulus(1);
        sBValid = 1'b0;
        applyStimulus(2);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("C.g%0d.dataOnce", g), sWHs[g], 1);
            checkOutput($sformatf("C.g%0d.addrOnce", g), sAwHs[g], 1);
            checkOutput($sformatf("C.g%0d.strb", g), lastStrb[g], 16'h000F);
            checkOutput($sformatf("C.g%0d.addr", g), lastAwAddr[g], 32'h0000_0020);
            checkOutput($sformatf("C.g%0d.m0NoResp", g), m0BValidCyc[g], 0);
            checkOutput($sformatf("C.g%0d.m1Resp", g), m1BHs[g], 1);
        end

        // D: m0 read concurrent with m1 write
        doReset();
        sArReady = 1'b1; sAwReady = 1'b1; sWReady = 1'b1;
        mArAddr[0] = 32'h40; mArValid[0] = 1'b1;
        mAwAddr[1] = 32'h80; mAwValid[1] = 1'b1; mWData[1] = 128'hABCD; mWStrb[1] = 16'hFFFF; mWValid[1] = 1'b1;
        applyStimulus(1);
        #1;
        checkOutput("D.sArValid", oSArValid[0], 1'b1);
        checkOutput("D.sAwValid", oSAwValid[0], 1'b1);
        checkOutput("D.m0.awReady", oAwReady[0][0], 1'b0);
        checkOutput("D.m1.arReady", oArReady[0][1], 1'b0);
        applyStimulus(1);
        mArValid[0] = 1'b0; mAwValid[1] = 1'b0; mWValid[1] = 1'b0;
        sRValid = 1'b1; sBValid = 1'b1; mRReady[0] = 1'b1; mBReady[1] = 1'b1;
        #1;
        checkOutput("D.m0.rValid", oRValid[0][0], 1'b1);
        checkOutput("D.m1.rValid", oRValid[0][1], 1'b0);
        checkOutput("D.m1.bValid", oBValid[0][1], 1'b1);
        checkOutput("D.m0.bValid", oBValid[0][0], 1'b0);
        applyStimulus(1);
        sRValid = 1'b0; sBValid = 1'b0;
        applyStimulus(2);
        checkOutput("D.bothActive", bothActive[0], 1);

        // E: grantee stalls its read data acceptance for five cycles while m1 waits
        doReset();
        sArReady = 1'b1;
        mArAddr[0] = 32'h300; mArAddr[1] = 32'h400;
        mArValid[0] = 1'b1; mArValid[1] = 1'b1; mRReady[1] = 1'b1;
        applyStimulus(2);
        mArValid[0] = 1'b0; sRValid = 1'b1;
        applyStimulus(5);
        checkOutput("E.sRReady.stalled", oSRReady[0], 1'b0);
        checkOutput("E.m0.rValid.held", oRValid[0][0], 1'b1);
        checkOutput("E.m1.arReady.blocked", oArReady[0][1], 1'b0);
        mRReady[0] = 1'b1;
        applyStimulus(2);
        #1;
        checkOutput("E.m1.granted", oArReady[0][1], 1'b1);
        applyStimulus(1);
        mArValid[1] = 1'b0;
        applyStimulus(2);
        sRValid = 1'b0;

        // F: reset while a write is waiting in the request phase restores m0-first arbitration
        doReset();
        sAwReady = 1'b1; sWReady = 1'b1; mBReady[0] = 1'b1; mBReady[1] = 1'b1;
        mAwAddr[0] = 32'h500; mAwValid[0] = 1'b1; mWValid[0] = 1'b1; mWStrb[0] = 16'h00F0;
        applyStimulus(2);
        mAwValid[0] = 1'b0; mWValid[0] = 1'b0; sBValid = 1'b1;
        applyStimulus(1);
        sBValid = 1'b0; sAwReady = 1'b0; sWReady = 1'b0;
        mAwAddr[1] = 32'h600; mAwValid[1] = 1'b1; mWValid[1] = 1'b1; mWStrb[1] = 16'h0F00;
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        mAwValid[0] = 1'b1; mWValid[0] = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("F.g%0d.sAwValid.idle", g), oSAwValid[g], 1'b0);
            checkOutput($sformatf("F.g%0d.sWValid.idle", g), oSWValid[g], 1'b0);
        end
        sAwReady = 1'b1; sWReady = 1'b1;
        applyStimulus(1);
        #1;
        checkOutput("F.rr.m0.awReady", oAwReady[0][0], 1'b1);
        checkOutput("F.rr.m1.awReady", oAwReady[0][1], 1'b0);
        checkOutput("F.prio.m0.awReady", oAwReady[1][0], 1'b1);
        applyStimulus(1);
        mAwValid[0] = 1'b0; mWValid[0] = 1'b0; mAwValid[1] = 1'b0; mWValid[1] = 1'b0;
        applyStimulus(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
